// File: rtl/uart_tx_controller_pkg.sv
// rtl/uart_tx_controller_pkg.sv - shared FSM encoding and baud counter width
package uart_tx_controller_pkg;

    localparam int BAUD_CNT_W = 14;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

endpackage

// File: rtl/uart_tx_controller_baud_rate_generator.sv
// rtl/uart_tx_controller_baud_rate_generator.sv - down-counting baud tick, one tick per BAUD_RATE_NUMBER+1 enabled cycles
module baud_rate_generator
    import uart_tx_controller_pkg::*;
#(
    parameter logic [BAUD_CNT_W-1:0] BAUD_RATE_NUMBER = 14'd20
) (
    input  logic clk,
    input  logic rst,
    input  logic count_en,
    output logic baud_rate_signal
);

    logic [BAUD_CNT_W-1:0] count_q;
    logic [BAUD_CNT_W-1:0] count_d;

    always_comb begin
        count_d          = count_q;
        baud_rate_signal = 1'b0;
        if (count_en) begin
            if (count_q == '0) begin
                baud_rate_signal = 1'b1;
                count_d          = BAUD_RATE_NUMBER;
            end else begin
                count_d = count_q - BAUD_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= BAUD_RATE_NUMBER;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_tx_controller.sv
// rtl/uart_tx_controller.sv - byte-wide valid/ready to serial UART transmitter with optional parity and 1/2 stop bits
module uart_tx_controller
    import uart_tx_controller_pkg::*;
#(
    parameter logic [BAUD_CNT_W-1:0] BAUD_RATE_NUMBER = 14'd20,
    parameter bit                    PARITY_EN        = 1'b0,
    parameter bit                    PARITY_ODD       = 1'b0,
    parameter int                    STOP_BITS        = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       busy,
    output logic       frame_done
);

    state_t     state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       stop_cnt_q, stop_cnt_d;
    logic       parity_q, parity_d;
    logic       tx_q, tx_d;
    logic       busy_q, busy_d;
    logic       tx_ready_q, tx_ready_d;
    logic       tick;
    logic       baud_rst;
    logic       last_stop;
    logic       done;

    // Holding the generator in reload while idle gives every start bit its full length.
    assign baud_rst  = rst || (state_q == ST_IDLE);
    assign last_stop = (STOP_BITS == 1) || stop_cnt_q;

    baud_rate_generator #(
        .BAUD_RATE_NUMBER(BAUD_RATE_NUMBER)
    ) u_baud (
        .clk             (clk),
        .rst             (baud_rst),
        .count_en        (state_q != ST_IDLE),
        .baud_rate_signal(tick)
    );

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        parity_d   = parity_q;
        done       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (tx_valid && tx_ready_q) begin
                    state_d    = ST_START;
                    shift_d    = tx_data;
                    parity_d   = (^tx_data) ^ PARITY_ODD;
                    bit_cnt_d  = 3'd0;
                    stop_cnt_d = 1'b0;
                end
            end
            ST_START: begin
                if (tick) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (tick) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_cnt_q == 3'd7) begin
                        state_d = PARITY_EN ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (tick) state_d = ST_STOP;
            end
            ST_STOP: begin
                if (tick) begin
                    if (last_stop) begin
                        state_d = ST_IDLE;
                        done    = 1'b1;
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered from next-state values so they line up with state_q.
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
            ST_PARITY: tx_d = parity_d;
            default:   tx_d = 1'b1;
        endcase
        busy_d     = (state_d != ST_IDLE);
        tx_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            shift_q    <= 8'd0;
            bit_cnt_q  <= 3'd0;
            stop_cnt_q <= 1'b0;
            parity_q   <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            tx_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            parity_q   <= parity_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            tx_ready_q <= tx_ready_d;
        end
    end

    assign tx         = tx_q;
    assign busy       = busy_q;
    assign tx_ready   = tx_ready_q;
    assign frame_done = done;

endmodule

// File: tb/tb_uart_tx_controller.sv
// tb/tb_uart_tx_controller.sv - scoreboard bench over four parameter variants of uart_tx_controller
module tb_uart_tx_controller;

    localparam int N_UNITS = 4;
    localparam int BIT_CYC = 21;

    typedef struct {
        logic [11:0] bits;
        int          nbits;
        int          gap_exp;
    } frame_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data    [N_UNITS];
    logic       tx_valid   [N_UNITS];
    logic       tx_ready   [N_UNITS];
    logic       tx_line    [N_UNITS];
    logic       busy       [N_UNITS];
    logic       frame_done [N_UNITS];

    int     checks;
    int     failures;
    longint cycle = 0;
    longint last_fd_cycle = -100;
    frame_t exp_q[$];
    int     cur_u;
    bit     mon_en;
    bit     in_frame;
    bit     watch;
    int     done_seen = 0;

    always #5 clk = ~clk;

    // Unit 0: defaults; 1: even parity; 2: odd parity; 3: two stop bits.
    genvar g;
    generate
        for (g = 0; g < N_UNITS; g++) begin : g_dut
            uart_tx_controller #(
                .BAUD_RATE_NUMBER(14'd20),
                .PARITY_EN       ((g == 1) || (g == 2)),
                .PARITY_ODD      (g == 2),
                .STOP_BITS       ((g == 3) ? 2 : 1)
            ) u_dut (
                .clk       (clk),
                .rst       (rst),
                .tx_data   (tx_data[g]),
                .tx_valid  (tx_valid[g]),
                .tx_ready  (tx_ready[g]),
                .tx        (tx_line[g]),
                .busy      (busy[g]),
                .frame_done(frame_done[g])
            );
        end
    endgenerate

    always @(posedge clk) cycle <= cycle + 1;

    always @(negedge clk) begin
        if (!watch) done_seen <= 0;
        else if (frame_done[0] === 1'b1) done_seen <= done_seen + 1;
    end

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic frame_t model_frame(input int u, input logic [7:0] d, input int gap);
        frame_t f;
        int     n;
        bit     pe;
        bit     odd;
        int     stops;
        pe    = (u == 1) || (u == 2);
        odd   = (u == 2);
        stops = (u == 3) ? 2 : 1;
        f.bits = '1;
        n = 0;
        f.bits[n] = 1'b0;
        n++;
        for (int i = 0; i < 8; i++) begin
            f.bits[n] = d[i];
            n++;
        end
        if (pe) begin
            f.bits[n] = (^d) ^ odd;
            n++;
        end
        for (int i = 0; i < stops; i++) begin
            f.bits[n] = 1'b1;
            n++;
        end
        f.nbits   = n;
        f.gap_exp = gap;
        return f;
    endfunction

    task automatic send(input int u, input logic [7:0] d, input bit hold, input int gap);
        int n;
        if (mon_en) exp_q.push_back(model_frame(u, d, gap));
        @(negedge clk);
        tx_valid[u] = 1'b1;
        tx_data[u]  = d;
        n = 0;
        while (tx_ready[u] !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (tx_ready[u] !== 1'b1) check_eq("handshake_timeout", 0, 1);
        @(posedge clk);
        #1;
        if (!hold) tx_valid[u] = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || in_frame) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check_eq("drain_in_time", (n < 3000) ? 1 : 0, 1);
    endtask

    initial begin : monitor
        frame_t f;
        longint start_cyc;
        int     good;
        int     fd_cnt;
        int     busy_cnt;
        bit     fd_last;
        in_frame = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en && tx_line[cur_u] === 1'b0) begin
                in_frame  = 1'b1;
                start_cyc = cycle;
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_start", 1, 0);
                end else begin
                    f = exp_q.pop_front();
                    if (f.gap_exp >= 0) check_eq("b2b_gap", start_cyc - last_fd_cycle, f.gap_exp);
                    fd_cnt   = 0;
                    busy_cnt = 0;
                    fd_last  = 1'b0;
                    for (int b = 0; b < f.nbits; b++) begin
                        good = 0;
                        for (int c = 0; c < BIT_CYC; c++) begin
                            if (b != 0 || c != 0) @(negedge clk);
                            if (tx_line[cur_u] === f.bits[b]) good++;
                            if (busy[cur_u] === 1'b1) busy_cnt++;
                            if (frame_done[cur_u] === 1'b1) begin
                                fd_cnt++;
                                last_fd_cycle = cycle;
                                fd_last = (b == f.nbits - 1) && (c == BIT_CYC - 1);
                            end
                        end
                        check_eq($sformatf("u%0d_bit%0d_cycles", cur_u, b), good, BIT_CYC);
                    end
                    check_eq("frame_done_count", fd_cnt, 1);
                    check_eq("frame_done_last_cycle", fd_last, 1);
                    check_eq("frame_len", last_fd_cycle - start_cyc + 1, f.nbits * BIT_CYC);
                    check_eq("busy_cycles", busy_cnt, f.nbits * BIT_CYC);
                    @(negedge clk);
                    check_eq("post_frame_tx_ready", tx_ready[cur_u], 1);
                    check_eq("post_frame_busy", busy[cur_u], 0);
                    check_eq("post_frame_tx", tx_line[cur_u], 1);
                end
                in_frame = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        checks   = 0;
        failures = 0;
        mon_en   = 1'b0;
        watch    = 1'b0;
        cur_u    = 0;
        for (int u = 0; u < N_UNITS; u++) begin
            tx_valid[u] = 1'b0;
            tx_data[u]  = 8'h00;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int u = 0; u < N_UNITS; u++) begin
            check_eq($sformatf("u%0d_reset_tx", u), tx_line[u], 1);
            check_eq($sformatf("u%0d_reset_tx_ready", u), tx_ready[u], 1);
            check_eq($sformatf("u%0d_reset_busy", u), busy[u], 0);
            check_eq($sformatf("u%0d_reset_frame_done", u), frame_done[u], 0);
        end
        rst    = 1'b0;
        mon_en = 1'b1;

        cur_u = 0; send(0, 8'h55, 1'b0, -1); wait_drain();
        cur_u = 1; send(1, 8'h55, 1'b0, -1); wait_drain();
        cur_u = 2; send(2, 8'h55, 1'b0, -1); wait_drain();
        cur_u = 3; send(3, 8'hA3, 1'b0, -1); wait_drain();

        cur_u = 1;
        for (int i = 0; i < 3; i++) begin
            send(1, 8'($urandom_range(0, 255)), 1'b0, -1);
            wait_drain();
        end

        cur_u = 0;
        send(0, 8'h55, 1'b1, -1);
        send(0, 8'hA3, 1'b0, 2);
        wait_drain();

        send(0, 8'hC9, 1'b0, -1);
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            tx_data[0]  = ~tx_data[0];
            tx_valid[0] = ~tx_valid[0];
        end
        tx_valid[0] = 1'b0;
        wait_drain();

        // Abort a frame during data bit 3 (0x34 has bit 3 = 0).
        mon_en = 1'b0;
        send(0, 8'h34, 1'b0, -1);
        repeat (94) @(negedge clk);
        check_eq("pre_reset_tx_bit3", tx_line[0], 0);
        check_eq("pre_reset_busy", busy[0], 1);
        watch = 1'b1;
        rst   = 1'b1;
        @(negedge clk);
        check_eq("abort_tx", tx_line[0], 1);
        check_eq("abort_tx_ready", tx_ready[0], 1);
        check_eq("abort_busy", busy[0], 0);
        check_eq("abort_frame_done", frame_done[0], 0);
        rst = 1'b0;
        repeat (300) @(negedge clk);
        check_eq("abort_no_frame_done", done_seen, 0);
        check_eq("abort_line_idle", tx_line[0], 1);
        watch  = 1'b0;
        mon_en = 1'b1;
        send(0, 8'h96, 1'b0, -1);
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
